// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: hex glyph table,
// blank code and bit positions within the {dp, g..a} segment byte.
package seg_pkg;

    typedef logic [6:0] seg7_t;

    localparam int SEG_A  = 0;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam seg7_t SEG_OFF = 7'h00;

    // Entry n is the gfedcba pattern for hex digit n (entry 0 is the LSB slice).
    localparam logic [15:0][6:0] HEX_SEG7 = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg_scan_driver_if.sv
// Bus between the OutPort side and the scan driver: capture inputs and
// display outputs. The master drives data/load/run, the driver is the slave.
interface seg_scan_driver_if;

    logic [31:0] data_in;
    logic        load;
    logic        run;
    logic [7:0]  digit_sel;
    logic [7:0]  seg_out;
    logic        frame_done;

    modport master (
        output data_in, load, run,
        input  digit_sel, seg_out, frame_done
    );

    modport slave (
        input  data_in, load, run,
        output digit_sel, seg_out, frame_done
    );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to gfedcba segment pattern (active-high).
module hex_to_seg7 (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    import seg_pkg::*;

    assign seg = HEX_SEG7[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed hex scan driver with frame-aligned double buffering and a
// run/halt indicator on digit 0's dp. Define SEG_BLANK_EN for leading-zero blanking.
module seg_scan_driver #(
    parameter int SCAN_DIV   = 50000,
    parameter int NUM_DIGITS = 8,
    parameter int ACTIVE_LOW = 1
) (
    input logic              clk,
    input logic              reset,
    seg_scan_driver_if.slave bus
);
    import seg_pkg::*;

    localparam int              PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]   PCNT_LAST = PW'(SCAN_DIV - 1);
    localparam logic [2:0]      IDX_LAST  = 3'(NUM_DIGITS - 1);
    localparam logic [7:0]      POLARITY  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [PW-1:0] pcnt;
    logic [2:0]    idx;
    logic [31:0]   shown;
    logic [31:0]   pending;
    logic          pend_v;

    logic          tick;
    logic          wrap;
    logic [3:0]    nibble;
    seg7_t         hex_seg;
    logic          blank_cur;
    logic [7:0]    sel_raw;
    logic [7:0]    seg_raw;

    assign tick   = (pcnt == PCNT_LAST);
    assign wrap   = tick && (idx == IDX_LAST);
    assign nibble = shown[{idx, 2'b00} +: 4];

    hex_to_seg7 u_hex (
        .nibble (nibble),
        .seg    (hex_seg)
    );

`ifdef SEG_BLANK_EN
    logic [7:0] blank_vec;

    // Walk from the top displayed nibble down; a digit blanks while everything above it is zero.
    always_comb begin : blank_scan
        logic upper_zero;
        upper_zero = 1'b1;
        blank_vec  = '0;
        for (int i = 7; i >= 0; i--) begin
            if (i < NUM_DIGITS) begin
                upper_zero   = upper_zero && (shown[4*i +: 4] == 4'h0);
                blank_vec[i] = upper_zero && (i != 0);
            end
        end
    end

    assign blank_cur = blank_vec[idx];
`else
    assign blank_cur = 1'b0;
`endif

    always_comb begin
        sel_raw                = 8'd1 << idx;
        seg_raw                = '0;
        seg_raw[SEG_G:SEG_A]   = blank_cur ? SEG_OFF : hex_seg;
        seg_raw[SEG_DP]        = (idx == 3'd0) && !bus.run;
    end

    // A load only touches the back buffer; shown swaps at the wrap so a frame never tears.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt           <= '0;
            idx            <= '0;
            shown          <= '0;
            pending        <= '0;
            pend_v         <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= wrap;
            if (tick) begin
                pcnt <= '0;
                idx  <= wrap ? 3'd0 : idx + 3'd1;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
            if (wrap && pend_v) begin
                shown <= pending;
            end
            if (bus.load) begin
                pending <= bus.data_in;
                pend_v  <= 1'b1;
            end else if (wrap) begin
                pend_v  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.digit_sel <= POLARITY;
            bus.seg_out   <= POLARITY;
        end else begin
            bus.digit_sel <= sel_raw ^ POLARITY;
            bus.seg_out   <= seg_raw ^ POLARITY;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed frame-by-frame bench for seg_scan_driver (SCAN_DIV=4, 8 digits, active-low).
module tb_seg_scan_driver;

    localparam int SCAN_DIV   = 4;
    localparam int NUM_DIGITS = 8;
    localparam int FRAME_LEN  = SCAN_DIV * NUM_DIGITS;
    localparam int NVEC       = 11;

`ifdef SEG_BLANK_EN
    localparam logic [7:0] LZ = 8'hFF;
`else
    localparam logic [7:0] LZ = 8'hC0;
`endif

    typedef struct {
        logic             run;
        int               step_a;
        logic [31:0]      data_a;
        int               step_b;
        logic [31:0]      data_b;
        logic [7:0][7:0]  exp_seg;
    } frame_vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    frame_vec_t vecs [NVEC];

    seg_scan_driver_if scan_bus ();

    seg_scan_driver #(
        .SCAN_DIV   (SCAN_DIV),
        .NUM_DIGITS (NUM_DIGITS),
        .ACTIVE_LOW (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (scan_bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic frame_vec_t mk_vec(input logic run, input int sa, input logic [31:0] da,
                                          input int sb, input logic [31:0] db,
                                          input logic [63:0] segs);
        frame_vec_t v;
        v.run     = run;
        v.step_a  = sa;
        v.data_a  = da;
        v.step_b  = sb;
        v.data_b  = db;
        v.exp_seg = segs;
        return v;
    endfunction

    // One full frame starting right after a wrap (or reset) edge; step 31 is the wrap edge.
    task automatic apply_stimulus(input int fi, input frame_vec_t v);
        scan_bus.run = v.run;
        for (int i = 0; i < FRAME_LEN; i++) begin
            int d;
            d = i / SCAN_DIV;
            if (i == v.step_a) begin
                scan_bus.load    = 1'b1;
                scan_bus.data_in = v.data_a;
            end else if (i == v.step_b) begin
                scan_bus.load    = 1'b1;
                scan_bus.data_in = v.data_b;
            end else begin
                scan_bus.load    = 1'b0;
            end
            step();
            check_output($sformatf("frame%0d step%0d digit_sel", fi, i), scan_bus.digit_sel, ~(8'd1 << d));
            check_output($sformatf("frame%0d step%0d seg_out", fi, i), scan_bus.seg_out, v.exp_seg[d]);
            check_output($sformatf("frame%0d step%0d frame_done", fi, i),
                         {7'd0, scan_bus.frame_done}, {7'd0, (i == FRAME_LEN - 1)});
        end
        scan_bus.load = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, " digit_sel"}, scan_bus.digit_sel, 8'hFF);
        check_output({tag, " seg_out"}, scan_bus.seg_out, 8'hFF);
        check_output({tag, " frame_done"}, {7'd0, scan_bus.frame_done}, 8'h00);
    endtask

    initial begin
        // Segment bytes are listed digit7 first, digit0 last.
        vecs[0]  = mk_vec(1'b0, -1, 32'h0,         -1, 32'h0,         {LZ, LZ, LZ, LZ, LZ, LZ, LZ, 8'h40});
        vecs[1]  = mk_vec(1'b1, 10, 32'h1234ABCD,  -1, 32'h0,         {LZ, LZ, LZ, LZ, LZ, LZ, LZ, 8'hC0});
        vecs[2]  = mk_vec(1'b1, -1, 32'h0,         -1, 32'h0,         {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h88, 8'h83, 8'hC6, 8'hA1});
        vecs[3]  = mk_vec(1'b1,  0, 32'h000000A5,  -1, 32'h0,         {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h88, 8'h83, 8'hC6, 8'hA1});
        vecs[4]  = mk_vec(1'b1, -1, 32'h0,         -1, 32'h0,         {LZ, LZ, LZ, LZ, LZ, LZ, 8'h88, 8'h92});
        vecs[5]  = mk_vec(1'b0, 31, 32'h00000001,  -1, 32'h0,         {LZ, LZ, LZ, LZ, LZ, LZ, 8'h88, 8'h12});
        vecs[6]  = mk_vec(1'b1,  5, 32'h00000002,  -1, 32'h0,         {LZ, LZ, LZ, LZ, LZ, LZ, 8'h88, 8'h92});
        vecs[7]  = mk_vec(1'b1,  2, 32'h00000077,  20, 32'h00000089,  {LZ, LZ, LZ, LZ, LZ, LZ, LZ, 8'hA4});
        vecs[8]  = mk_vec(1'b1,  4, 32'h00000044,  31, 32'h00000055,  {LZ, LZ, LZ, LZ, LZ, LZ, 8'h80, 8'h90});
        vecs[9]  = mk_vec(1'b1, -1, 32'h0,         -1, 32'h0,         {LZ, LZ, LZ, LZ, LZ, LZ, 8'h99, 8'h99});
        vecs[10] = mk_vec(1'b1, -1, 32'h0,         -1, 32'h0,         {LZ, LZ, LZ, LZ, LZ, LZ, 8'h92, 8'h92});

        reset            = 1'b1;
        scan_bus.run     = 1'b0;
        scan_bus.load    = 1'b0;
        scan_bus.data_in = 32'h0;

        for (int r = 0; r < 3; r++) begin
            step();
            check_reset_state($sformatf("reset cycle%0d", r));
        end
        reset = 1'b0;

        for (int fi = 0; fi < NVEC; fi++) begin
            apply_stimulus(fi, vecs[fi]);
        end

        $display("[TB] reset with a pending load");
        scan_bus.load    = 1'b1;
        scan_bus.data_in = 32'hDEADBEEF;
        step();
        scan_bus.load    = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        check_reset_state("mid-frame reset");
        step();
        reset = 1'b0;
        apply_stimulus(100, mk_vec(1'b1, -1, 32'h0, -1, 32'h0, {LZ, LZ, LZ, LZ, LZ, LZ, LZ, 8'hC0}));
        apply_stimulus(101, mk_vec(1'b1, -1, 32'h0, -1, 32'h0, {LZ, LZ, LZ, LZ, LZ, LZ, LZ, 8'hC0}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
